flt_irq_ctrl: RTL and testbench
===============================

FLT_IRQ_CTRL -- requirements
Module: flt_irq_ctrl

Interface
REQ-001 SHALL have parameter CH_N, default 8, number of fault channels (1..32).
REQ-002 SHALL have parameter FREQ, default 64'd100_000_000, clock frequency in Hz.
REQ-003 SHALL have parameter GAP_NS, default 64'd100, minimum irq-low gap in ns; GAP_CYC = GAP_NS*FREQ/1_000_000_000.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic rises on posedge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port flt_in, input, CH_N, debounced fault levels, 1 = fault active.
REQ-007 SHALL have port mask_wr, input, 1, one-cycle strobe loading mask from mask_wdata.
REQ-008 SHALL have port mask_wdata, input, CH_N, new mask, 1 = channel masked.
REQ-009 SHALL have port clr_wr, input, 1, one-cycle strobe, write-1-to-clear pending from clr_wdata.
REQ-010 SHALL have port clr_wdata, input, CH_N, pending bits to clear.
REQ-011 SHALL have port cnt_clr, input, 1, one-cycle strobe zeroing all event counters.
REQ-012 SHALL have port rd_sel, input, 5, channel index for counter readback.
REQ-013 SHALL have port rd_cnt, output, 8, registered event count of channel rd_sel.
REQ-014 SHALL have port pend, output, CH_N, sticky pending bits.
REQ-015 SHALL have port mask, output, CH_N, current mask register.
REQ-016 SHALL have port first_id, output, 5, index of first channel to go pending.
REQ-017 SHALL have port first_vld, output, 1, first_id valid.
REQ-018 SHALL have port irq, output, 1, level interrupt to host.

Function
REQ-019 SHALL register flt_in into flt_d each cycle; event[i] = flt_in[i] & ~flt_d[i] (rising edge, 1-cycle detect latency).
REQ-020 SHALL set pend[i] on the cycle after event[i], regardless of mask[i].
REQ-021 SHALL clear pend[i] the cycle after clr_wr with clr_wdata[i]=1; set SHALL win over clear in the same cycle.
REQ-022 SHALL increment counter[i] on event[i], saturating at 255; cnt_clr and event same cycle SHALL yield 0.
REQ-023 SHALL load mask from mask_wdata the cycle after mask_wr; masking SHALL NOT alter pend.
REQ-024 SHALL update rd_cnt one cycle after rd_sel; rd_sel >= CH_N SHALL return 0.
REQ-025 SHALL capture first_id and set first_vld when pend goes from all-zero to non-zero; lowest index wins on simultaneous events.
REQ-026 SHALL hold first_id/first_vld until pend returns all-zero, then clear first_vld the next cycle.
REQ-027 SHALL run irq FSM with states IDLE, ASSERT, GAP; act = |(pend & ~mask).
REQ-028 IDLE -> ASSERT when act; ASSERT -> GAP when !act (GAP_CYC>0) or -> IDLE (GAP_CYC==0).
REQ-029 GAP SHALL count GAP_CYC cycles with irq low, then go IDLE, ignoring act until expiry.
REQ-030 irq SHALL be registered and equal 1 exactly in ASSERT.

Reset
REQ-031 On rst: flt_d, pend, mask, counters, rd_cnt, first_id, first_vld, irq SHALL be 0; FSM SHALL be IDLE.
REQ-032 A fault already active at reset release SHALL count as an event (flt_d resets to 0).
REQ-033 rst asserted mid-GAP or mid-ASSERT SHALL drop irq immediately and abort the gap timer.

Structure
REQ-034 Shared package flt_pkg SHALL hold CNT_W=8, IDX_W=5, FSM state encodings and a clog2 function.
REQ-035 Per-channel logic (edge detect, pending bit, saturating counter) SHALL be sub-module flt_ch, instantiated CH_N times.

Verification (FREQ=100 MHz, GAP_NS=100 -> GAP_CYC=10, CH_N=8)
REQ-036 flt_in[3] 0->1 -> pend=0x08 next cycle, irq=1 one cycle later, first_id=3, counter[3]=1.
REQ-037 clr_wr=1, clr_wdata=0x08 -> pend=0, irq low for exactly 10 cycles; flt_in[5] rises during gap -> irq returns after gap end +1.
REQ-038 mask=0x20, flt_in[5] rises -> pend=0x20, irq stays 0; mask_wr to 0x00 -> irq=1.
REQ-039 flt_in[2] and [6] rise same cycle -> first_id=2, pend=0x44; clr_wr on bit 2 same cycle as a new edge on 2 -> pend[2] stays 1.
REQ-040 300 edges on channel 0 -> rd_cnt=255 with rd_sel=0; cnt_clr -> rd_cnt=0; rd_sel=9 -> 0.
REQ-041 rst pulse while irq=1 with flt_in=0x01 held -> irq, pend 0 during reset; after release pend=0x01 and irq reasserts.

Source files
------------

// File: rtl/flt_pkg.sv
// Shared constants, irq FSM state encoding and a constant-friendly clog2
// for the fault interrupt controller.
package flt_pkg;

  localparam int CNT_W = 8;
  localparam int IDX_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GAP    = 2'd2
  } irq_state_t;

  function automatic int clog2(input longint unsigned v);
    int r;
    longint unsigned x;
    r = 0;
    x = 64'd1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/flt_ch.sv
// One fault channel: rising-edge detect, sticky pending bit and a
// saturating event counter.
module flt_ch
  import flt_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flt,
  input  logic             clr,
  input  logic             cnt_clr,
  output logic             evt,
  output logic             pend,
  output logic [CNT_W-1:0] cnt
);

  logic flt_d;

  // flt_d resets low so a fault held through reset release is an event
  assign evt = flt & ~flt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flt_d <= 1'b0;
      pend  <= 1'b0;
      cnt   <= '0;
    end else begin
      flt_d <= flt;
      pend  <= (pend & ~clr) | evt;
      if (cnt_clr)
        cnt <= '0;
      else if (evt && (cnt != {CNT_W{1'b1}}))
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/flt_irq_ctrl.sv
// Fault interrupt controller: per-channel pending/counters, mask, first-fault
// capture and a level irq with an enforced minimum low gap.
module flt_irq_ctrl
  import flt_pkg::*;
#(
  parameter int          CH_N   = 8,
  parameter logic [63:0] FREQ   = 64'd100_000_000,
  parameter logic [63:0] GAP_NS = 64'd100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH_N-1:0]  flt_in,
  input  logic             mask_wr,
  input  logic [CH_N-1:0]  mask_wdata,
  input  logic             clr_wr,
  input  logic [CH_N-1:0]  clr_wdata,
  input  logic             cnt_clr,
  input  logic [4:0]       rd_sel,
  output logic [7:0]       rd_cnt,
  output logic [CH_N-1:0]  pend,
  output logic [CH_N-1:0]  mask,
  output logic [4:0]       first_id,
  output logic             first_vld,
  output logic             irq
);

  localparam logic [63:0] GAP_CYC = GAP_NS * FREQ / 64'd1_000_000_000;
  localparam int GAP_W = (clog2(GAP_CYC + 64'd1) < 1) ? 1 : clog2(GAP_CYC + 64'd1);

  logic [CH_N-1:0]  evt;
  logic [CH_N-1:0]  clr_vec;
  logic [CNT_W-1:0] cnt [CH_N];
  logic [CNT_W-1:0] rd_nxt;
  logic [IDX_W-1:0] low_idx;
  logic             act;
  irq_state_t       state;
  logic [GAP_W-1:0] gap_cnt;

  assign clr_vec = clr_wr ? clr_wdata : '0;
  assign act     = |(pend & ~mask);

  for (genvar gi = 0; gi < CH_N; gi++) begin : g_ch
    flt_ch u_ch (
      .clk     (clk),
      .rst     (rst),
      .flt     (flt_in[gi]),
      .clr     (clr_vec[gi]),
      .cnt_clr (cnt_clr),
      .evt     (evt[gi]),
      .pend    (pend[gi]),
      .cnt     (cnt[gi])
    );
  end

  // Out-of-range selects fall through to zero
  always_comb begin
    rd_nxt = '0;
    for (int i = 0; i < CH_N; i++)
      if (rd_sel == IDX_W'(i)) rd_nxt = cnt[i];
  end

  always_comb begin
    low_idx = '0;
    for (int i = CH_N - 1; i >= 0; i--)
      if (evt[i]) low_idx = IDX_W'(i);
  end

  // While pend is all-zero, the next pend equals this cycle's events
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask      <= '0;
      rd_cnt    <= '0;
      first_id  <= '0;
      first_vld <= 1'b0;
    end else begin
      if (mask_wr) mask <= mask_wdata;
      rd_cnt <= rd_nxt;
      if (pend == '0) begin
        if (evt != '0) begin
          first_id  <= low_idx;
          first_vld <= 1'b1;
        end else begin
          first_vld <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      gap_cnt <= '0;
      irq     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (act) begin
            state <= ST_ASSERT;
            irq   <= 1'b1;
          end
        end
        ST_ASSERT: begin
          if (!act) begin
            irq     <= 1'b0;
            gap_cnt <= '0;
            state   <= (GAP_CYC == 64'd0) ? ST_IDLE : ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYC - 64'd1))
            state <= ST_IDLE;
          else
            gap_cnt <= gap_cnt + 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          irq   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flt_irq_ctrl.sv
// Self-checking bench for flt_irq_ctrl: directed scenarios plus a randomized
// run against a behavioural model of pend/mask/counters/first-fault.
module tb_flt_irq_ctrl;

  localparam int CH_N = 8;
  localparam int GAP_CYC = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH_N-1:0] flt_in;
  logic            mask_wr;
  logic [CH_N-1:0] mask_wdata;
  logic            clr_wr;
  logic [CH_N-1:0] clr_wdata;
  logic            cnt_clr;
  logic [4:0]      rd_sel;
  logic [7:0]      rd_cnt;
  logic [CH_N-1:0] pend;
  logic [CH_N-1:0] mask;
  logic [4:0]      first_id;
  logic            first_vld;
  logic            irq;

  int tests = 0;
  int fails = 0;

  flt_irq_ctrl #(.CH_N(CH_N), .FREQ(64'd100_000_000), .GAP_NS(64'd100)) dut (
    .clk        (clk),
    .rst        (rst),
    .flt_in     (flt_in),
    .mask_wr    (mask_wr),
    .mask_wdata (mask_wdata),
    .clr_wr     (clr_wr),
    .clr_wdata  (clr_wdata),
    .cnt_clr    (cnt_clr),
    .rd_sel     (rd_sel),
    .rd_cnt     (rd_cnt),
    .pend       (pend),
    .mask       (mask),
    .first_id   (first_id),
    .first_vld  (first_vld),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flt_in = '0; mask_wr = 0; mask_wdata = '0; clr_wr = 0; clr_wdata = '0;
    cnt_clr = 0; rd_sel = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic clear_all_and_settle();
    flt_in = '0;
    clr_wr = 1; clr_wdata = '1;
    tick();
    clr_wr = 0; clr_wdata = '0;
    repeat (2 * GAP_CYC) tick();
  endtask

  function automatic logic [4:0] lowest_set(input logic [CH_N-1:0] v);
    for (int i = 0; i < CH_N; i++)
      if (v[i]) return 5'(i);
    return 5'd0;
  endfunction

  task automatic test_reset();
    do_reset();
    tests++; if (pend !== 8'h00) begin fails++; $display("[TB] FAIL reset_pend got %h exp 00", pend); end
    tests++; if (mask !== 8'h00) begin fails++; $display("[TB] FAIL reset_mask got %h exp 00", mask); end
    tests++; if (irq !== 1'b0) begin fails++; $display("[TB] FAIL reset_irq got %b exp 0", irq); end
    tests++; if (first_vld !== 1'b0 || first_id !== 5'd0) begin fails++; $display("[TB] FAIL reset_first got vld=%b id=%0d exp 0/0", first_vld, first_id); end
    tests++; if (rd_cnt !== 8'd0) begin fails++; $display("[TB] FAIL reset_rdcnt got %0d exp 0", rd_cnt); end
  endtask

  task automatic test_single_fault();
    flt_in = 8'h08;
    tick();
    tests++; if (pend !== 8'h08) begin fails++; $display("[TB] FAIL single_pend got %h exp 08", pend); end
    tests++; if (irq !== 1'b0) begin fails++; $display("[TB] FAIL single_irq_early got %b exp 0", irq); end
    tests++; if (first_vld !== 1'b1 || first_id !== 5'd3) begin fails++; $display("[TB] FAIL single_first got vld=%b id=%0d exp 1/3", first_vld, first_id); end
    rd_sel = 5'd3;
    tick();
    tests++; if (irq !== 1'b1) begin fails++; $display("[TB] FAIL single_irq got %b exp 1", irq); end
    tests++; if (rd_cnt !== 8'd1) begin fails++; $display("[TB] FAIL single_cnt got %0d exp 1", rd_cnt); end
  endtask

  task automatic test_gap();
    int lows;
    clr_wr = 1; clr_wdata = 8'h08;
    tick();
    clr_wr = 0; clr_wdata = '0;
    tests++; if (pend !== 8'h00) begin fails++; $display("[TB] FAIL gap_clr_pend got %h exp 00", pend); end
    tests++; if (irq !== 1'b1) begin fails++; $display("[TB] FAIL gap_irq_hold got %b exp 1", irq); end
    tick();
    tests++; if (irq !== 1'b0) begin fails++; $display("[TB] FAIL gap_irq_drop got %b exp 0", irq); end
    flt_in = 8'h28;
    lows = 1;
    while (irq === 1'b0 && lows < 40) begin
      tick();
      if (irq === 1'b0) lows++;
    end
    tests++; if (lows !== GAP_CYC + 1) begin fails++; $display("[TB] FAIL gap_low_cycles got %0d exp %0d", lows, GAP_CYC + 1); end
    tests++; if (pend !== 8'h20) begin fails++; $display("[TB] FAIL gap_pend got %h exp 20", pend); end
  endtask

  task automatic test_mask();
    clear_all_and_settle();
    tests++; if (irq !== 1'b0) begin fails++; $display("[TB] FAIL mask_idle_irq got %b exp 0", irq); end
    mask_wr = 1; mask_wdata = 8'h20;
    tick();
    mask_wr = 0;
    tests++; if (mask !== 8'h20) begin fails++; $display("[TB] FAIL mask_load got %h exp 20", mask); end
    flt_in = 8'h20;
    tick();
    tests++; if (pend !== 8'h20) begin fails++; $display("[TB] FAIL mask_pend got %h exp 20", pend); end
    repeat (5) tick();
    tests++; if (irq !== 1'b0) begin fails++; $display("[TB] FAIL mask_irq_blocked got %b exp 0", irq); end
    mask_wr = 1; mask_wdata = 8'h00;
    tick();
    mask_wr = 0;
    tests++; if (mask !== 8'h00 || pend !== 8'h20) begin fails++; $display("[TB] FAIL mask_unmask got mask=%h pend=%h exp 00/20", mask, pend); end
    tick();
    tests++; if (irq !== 1'b1) begin fails++; $display("[TB] FAIL mask_irq got %b exp 1", irq); end
  endtask

  task automatic test_simultaneous();
    clear_all_and_settle();
    tests++; if (first_vld !== 1'b0) begin fails++; $display("[TB] FAIL simul_vld_cleared got %b exp 0", first_vld); end
    flt_in = 8'h44;
    tick();
    tests++; if (pend !== 8'h44) begin fails++; $display("[TB] FAIL simul_pend got %h exp 44", pend); end
    tests++; if (first_vld !== 1'b1 || first_id !== 5'd2) begin fails++; $display("[TB] FAIL simul_first got vld=%b id=%0d exp 1/2", first_vld, first_id); end
    flt_in = 8'h40;
    tick();
    flt_in = 8'h44; clr_wr = 1; clr_wdata = 8'h04;
    tick();
    clr_wr = 0; clr_wdata = '0;
    tests++; if (pend !== 8'h44) begin fails++; $display("[TB] FAIL simul_set_wins got %h exp 44", pend); end
  endtask

  task automatic test_saturate();
    flt_in = '0; cnt_clr = 1;
    tick();
    cnt_clr = 0;
    for (int i = 0; i < 300; i++) begin
      flt_in = 8'h01; tick();
      flt_in = 8'h00; tick();
    end
    rd_sel = 5'd0;
    tick();
    tests++; if (rd_cnt !== 8'd255) begin fails++; $display("[TB] FAIL sat_cnt got %0d exp 255", rd_cnt); end
    flt_in = 8'h01; cnt_clr = 1;
    tick();
    flt_in = 8'h00; cnt_clr = 0;
    tick();
    tests++; if (rd_cnt !== 8'd0) begin fails++; $display("[TB] FAIL sat_clr_with_event got %0d exp 0", rd_cnt); end
    flt_in = 8'h02; tick();
    flt_in = 8'h00; rd_sel = 5'd1; tick();
    tick();
    tests++; if (rd_cnt !== 8'd1) begin fails++; $display("[TB] FAIL sel1_cnt got %0d exp 1", rd_cnt); end
    rd_sel = 5'd9;
    tick();
    tests++; if (rd_cnt !== 8'd0) begin fails++; $display("[TB] FAIL sel_oob got %0d exp 0", rd_cnt); end
  endtask

  task automatic test_random();
    logic [CH_N-1:0] m_prev, m_pend, m_mask, rise, old;
    logic [7:0]      m_cnt [CH_N];
    logic [7:0]      m_rd;
    logic [4:0]      m_fid;
    logic            m_fvld;
    do_reset();
    m_prev = '0; m_pend = '0; m_mask = '0; m_rd = '0; m_fid = '0; m_fvld = 0;
    for (int i = 0; i < CH_N; i++) m_cnt[i] = '0;
    for (int c = 0; c < 400; c++) begin
      flt_in     = flt_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      mask_wr    = ($urandom_range(0, 7) == 0);
      mask_wdata = 8'($urandom);
      clr_wr     = ($urandom_range(0, 3) == 0);
      clr_wdata  = 8'($urandom);
      cnt_clr    = ($urandom_range(0, 31) == 0);
      rd_sel     = 5'($urandom_range(0, 10));
      rise   = flt_in & ~m_prev;
      m_prev = flt_in;
      old    = m_pend;
      m_rd   = (rd_sel < 5'(CH_N)) ? m_cnt[int'(rd_sel)] : 8'd0;
      for (int i = 0; i < CH_N; i++) begin
        if (cnt_clr) m_cnt[i] = 8'd0;
        else if (rise[i] && m_cnt[i] < 8'd255) m_cnt[i] = m_cnt[i] + 8'd1;
      end
      m_pend = (old & ~(clr_wr ? clr_wdata : 8'h00)) | rise;
      if (mask_wr) m_mask = mask_wdata;
      if (old == '0) begin
        if (m_pend != '0) begin m_fid = lowest_set(m_pend); m_fvld = 1; end
        else m_fvld = 0;
      end
      tick();
      tests++; if (pend !== m_pend) begin fails++; $display("[TB] FAIL rnd_pend cyc %0d got %h exp %h", c, pend, m_pend); end
      tests++; if (mask !== m_mask) begin fails++; $display("[TB] FAIL rnd_mask cyc %0d got %h exp %h", c, mask, m_mask); end
      tests++; if (rd_cnt !== m_rd) begin fails++; $display("[TB] FAIL rnd_rdcnt cyc %0d got %0d exp %0d", c, rd_cnt, m_rd); end
      tests++; if (first_vld !== m_fvld || (m_fvld && first_id !== m_fid)) begin fails++; $display("[TB] FAIL rnd_first cyc %0d got vld=%b id=%0d exp %b/%0d", c, first_vld, first_id, m_fvld, m_fid); end
    end
    mask_wr = 0; clr_wr = 0; cnt_clr = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    flt_in = 8'h01;
    tick();
    tick();
    tests++; if (irq !== 1'b1) begin fails++; $display("[TB] FAIL rstmid_pre_irq got %b exp 1", irq); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++; if (irq !== 1'b0 || pend !== 8'h00) begin fails++; $display("[TB] FAIL rstmid_async got irq=%b pend=%h exp 0/00", irq, pend); end
    tick();
    tests++; if (irq !== 1'b0 || pend !== 8'h00) begin fails++; $display("[TB] FAIL rstmid_held got irq=%b pend=%h exp 0/00", irq, pend); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    tests++; if (pend !== 8'h01) begin fails++; $display("[TB] FAIL rstmid_pend got %h exp 01", pend); end
    tick();
    tests++; if (irq !== 1'b1) begin fails++; $display("[TB] FAIL rstmid_irq got %b exp 1", irq); end
  endtask

  initial begin
    test_reset();
    test_single_fault();
    test_gap();
    test_mask();
    test_simultaneous();
    test_saturate();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
